bus_dest_bank: RTL

- Destination (write) end of the internal datapath bus: the source side drives one selected register onto the bus; this block captures the bus word into exactly one destination register per cycle.
- Decodes an encoded 5-bit destination code into a one-hot load enable.
- Holds the architectural/datapath registers: R0–R15, HI, LO, Y, MAR, PC, MDR, IR, OutPort.
- Also handles the PC increment, the MDR memory-load path and an invalid-destination error flag.
- Its register outputs feed the source-side bus multiplexer inputs.

---
 rtl/cpu_bus_pkg.sv | 40 ++++
 rtl/dec_5_32.sv | 14 +
 rtl/bus_dest_bank.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared datapath-bus definitions: destination/source code map, widths and
// the write-bank startup states.
package cpu_bus_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned NDEST = 24;

  typedef enum logic [4:0] {
    DEST_R0      = 5'd0,
    DEST_R1      = 5'd1,
    DEST_R2      = 5'd2,
    DEST_R3      = 5'd3,
    DEST_R4      = 5'd4,
    DEST_R5      = 5'd5,
    DEST_R6      = 5'd6,
    DEST_R7      = 5'd7,
    DEST_R8      = 5'd8,
    DEST_R9      = 5'd9,
    DEST_R10     = 5'd10,
    DEST_R11     = 5'd11,
    DEST_R12     = 5'd12,
    DEST_R13     = 5'd13,
    DEST_R14     = 5'd14,
    DEST_R15     = 5'd15,
    DEST_HI      = 5'd16,
    DEST_LO      = 5'd17,
    DEST_Y       = 5'd18,
    DEST_MAR     = 5'd19,
    DEST_PC      = 5'd20,
    DEST_MDR     = 5'd21,
    DEST_IR      = 5'd22,
    DEST_OUTPORT = 5'd23
  } dest_code_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bank_state_e;

endpackage

// File: rtl/dec_5_32.sv
// Combinational 5-to-32 one-hot decoder with enable; inverse of the
// source-side priority encoder.
module dec_5_32 (
  input  logic        i_en,
  input  logic [4:0]  i_code,
  output logic [31:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/bus_dest_bank.sv
// Write end of the datapath bus: captures bus_in into one decoded destination
// register per cycle, plus PC increment, MDR memory load and error tracking.
module bus_dest_bank
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DW      = cpu_bus_pkg::DW,
  parameter int unsigned NDEST   = cpu_bus_pkg::NDEST,
  parameter int unsigned PC_STEP = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [DW-1:0]       bus_in,
  input  logic [4:0]          dest_code,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                inc_pc,
  input  logic                mem_read,
  input  logic [DW-1:0]       mem_data,
  output logic [DW*NDEST-1:0] regs_flat,
  output logic [15:0]         wr_count,
  output logic                dest_err,
  output logic [4:0]          err_code
);

  bank_state_e      r_state;
  bank_state_e      w_state_next;
  logic [DW-1:0]    r_regs [NDEST];
  logic [15:0]      r_wr_count;
  logic             r_dest_err;
  logic [4:0]       r_err_code;
  logic             w_accept;
  logic [31:0]      w_dec;
  logic [NDEST-1:0] w_wen;
  logic             w_bad;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= ST_INIT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  assign wr_ready = (r_state == ST_RUN);
  assign w_accept = wr_valid & wr_ready;

  dec_5_32 u_dec (
    .i_en     (w_accept),
    .i_code   (dest_code),
    .o_onehot (w_dec)
  );

  assign w_wen = w_dec[NDEST-1:0];

  // Any decoded line above the implemented range marks an invalid destination.
  generate
    if (NDEST < 32) begin : g_bad
      assign w_bad = |w_dec[31:NDEST];
    end else begin : g_nobad
      assign w_bad = 1'b0;
    end
  endgenerate

  // Later non-blocking assignments win: bus write beats inc_pc on PC,
  // and mem_read beats a bus write on MDR.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned k = 0; k < NDEST; k++) r_regs[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NDEST; k++) begin
        if (w_wen[k]) r_regs[k] <= bus_in;
      end
      if (inc_pc && wr_ready && !w_wen[DEST_PC])
        r_regs[DEST_PC] <= r_regs[DEST_PC] + DW'(PC_STEP);
      if (mem_read)
        r_regs[DEST_MDR] <= mem_data;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wr_count <= '0;
      r_dest_err <= 1'b0;
      r_err_code <= '0;
    end else begin
      if (|w_wen) r_wr_count <= r_wr_count + 16'd1;
      if (w_bad) begin
        r_dest_err <= 1'b1;
        if (!r_dest_err) r_err_code <= dest_code;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned k = 0; k < NDEST; k++) regs_flat[DW*k +: DW] = r_regs[k];
  end

  assign wr_count = r_wr_count;
  assign dest_err = r_dest_err;
  assign err_code = r_err_code;

endmodule
